// File: rtl/egress_requester.sv
// Descriptor-driven frame streamer: reads frame words into a 2-entry buffer and
// presents them on AXI-Stream, retrying ungranted requests with backoff before dropping.
module egress_requester #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 11,
    parameter int DEST_WIDTH  = 2,
    parameter int TIMEOUT_W   = 3,
    parameter int MAX_RETRIES = 3,
    parameter int BACKOFF     = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [2*(ADDR_WIDTH+1)+DEST_WIDTH-1:0] sideband_rdata,
    input  logic                                  sideband_empty,
    output logic                                  sideband_ren,
    output logic [ADDR_WIDTH-1:0]                 frame_raddr,
    output logic                                  frame_ren,
    input  logic [DATA_WIDTH-1:0]                 frame_rdata,
    output logic                                  frame_release,
    output logic [ADDR_WIDTH:0]                   release_ptr,
    output logic [DATA_WIDTH-1:0]                 egress_tdata,
    output logic                                  egress_tvalid,
    input  logic                                  egress_tready,
    output logic                                  egress_tlast,
    output logic [DEST_WIDTH-1:0]                 egress_tdest,
    output logic [15:0]                           frames_sent,
    output logic [15:0]                           frames_dropped
);

    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam int SB_W  = 2 * PTR_W + DEST_WIDTH;
    localparam int CNT_W = TIMEOUT_W + 1;
    localparam int RT_W  = $clog2(MAX_RETRIES + 1);
    localparam int BO_W  = $clog2(BACKOFF + 1);

    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(1) << TIMEOUT_W;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_READ_SB = 3'd1;
    localparam logic [2:0] S_REQUEST = 3'd2;
    localparam logic [2:0] S_STREAM  = 3'd3;
    localparam logic [2:0] S_BACKOFF = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]                       state_q, state_d;
    logic [PTR_W-1:0]                 start_q, start_d;
    logic [PTR_W-1:0]                 end_q, end_d;
    logic [DEST_WIDTH-1:0]            dest_q, dest_d;
    logic [PTR_W-1:0]                 rd_ptr_q, rd_ptr_d;
    logic [RT_W-1:0]                  retries_q, retries_d;
    logic [CNT_W-1:0]                 tmo_q, tmo_d;
    logic [BO_W-1:0]                  bo_q, bo_d;
    logic                             drop_q, drop_d;
    logic [1:0]                       occ_q, occ_d;
    logic [1:0][DATA_WIDTH-1:0]       buf_data_q, buf_data_d;
    logic [1:0]                       buf_last_q, buf_last_d;
    logic                             infl_q, infl_d;
    logic                             infl_last_q, infl_last_d;
    logic [15:0]                      sent_q, sent_d;
    logic [15:0]                      dropped_q, dropped_d;

    logic [PTR_W-1:0]      sb_start, sb_end, rd_next;
    logic [DEST_WIDTH-1:0] sb_dest;
    logic                  active, timeout, head_vld, head_last, tvalid_int, hs, rd_go, empty_desc;
    logic [DATA_WIDTH-1:0] head_data;

    assign sb_start = sideband_rdata[SB_W-1 -: PTR_W];
    assign sb_end   = sideband_rdata[DEST_WIDTH +: PTR_W];
    assign sb_dest  = sideband_rdata[DEST_WIDTH-1:0];

    assign active  = (state_q == S_REQUEST) || (state_q == S_STREAM);
    assign timeout = (state_q == S_REQUEST) && (tmo_q == TMO_LIMIT);
    assign rd_next = rd_ptr_q + PTR_W'(1);

    // With the buffer empty, the word returning from the frame buffer is presented
    // directly so a sustained stream needs no bubble cycles.
    assign head_vld   = (occ_q != 2'd0) || infl_q;
    assign head_data  = (occ_q != 2'd0) ? buf_data_q[0] : frame_rdata;
    assign head_last  = (occ_q != 2'd0) ? buf_last_q[0] : infl_last_q;
    assign tvalid_int = !reset && active && head_vld && !timeout;
    assign hs         = tvalid_int && egress_tready;

    assign rd_go = !reset && active && !timeout && (rd_ptr_q != end_q)
                   && ((occ_q + {1'b0, infl_q}) < 2'd2);

    assign empty_desc = (state_q == S_READ_SB) && (sb_start == sb_end);

    assign sideband_ren   = !reset && (state_q == S_IDLE) && !sideband_empty;
    assign frame_ren      = rd_go;
    assign frame_raddr    = rd_ptr_q[ADDR_WIDTH-1:0];
    assign frame_release  = !reset && ((state_q == S_DONE) || empty_desc);
    assign release_ptr    = !frame_release ? '0 : ((state_q == S_DONE) ? end_q : sb_end);
    assign egress_tvalid  = tvalid_int;
    assign egress_tdata   = tvalid_int ? head_data : '0;
    assign egress_tlast   = tvalid_int && head_last;
    assign egress_tdest   = dest_q;
    assign frames_sent    = sent_q;
    assign frames_dropped = dropped_q;

    always_comb begin
        state_d     = state_q;
        start_d     = start_q;
        end_d       = end_q;
        dest_d      = dest_q;
        rd_ptr_d    = rd_ptr_q;
        retries_d   = retries_q;
        tmo_d       = tmo_q;
        bo_d        = bo_q;
        drop_d      = drop_q;
        occ_d       = occ_q;
        buf_data_d  = buf_data_q;
        buf_last_d  = buf_last_q;
        sent_d      = sent_q;
        dropped_d   = dropped_q;
        infl_d      = rd_go;
        infl_last_d = rd_go && (rd_next == end_q);

        if (rd_go) begin
            rd_ptr_d = rd_next;
        end

        if (hs && (occ_q != 2'd0)) begin
            buf_data_d[0] = buf_data_q[1];
            buf_last_d[0] = buf_last_q[1];
            occ_d         = occ_q - 2'd1;
        end
        // Returning word is stored unless it was consumed straight off the bypass.
        if (infl_q && !(hs && (occ_q == 2'd0))) begin
            if (occ_d == 2'd0) begin
                buf_data_d[0] = frame_rdata;
                buf_last_d[0] = infl_last_q;
            end else begin
                buf_data_d[1] = frame_rdata;
                buf_last_d[1] = infl_last_q;
            end
            occ_d = occ_d + 2'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (sideband_ren) begin
                    state_d = S_READ_SB;
                end
            end
            S_READ_SB: begin
                start_d   = sb_start;
                end_d     = sb_end;
                dest_d    = sb_dest;
                rd_ptr_d  = sb_start;
                retries_d = '0;
                tmo_d     = '0;
                bo_d      = '0;
                drop_d    = 1'b0;
                if (sb_start == sb_end) begin
                    dropped_d = dropped_q + 16'd1;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_REQUEST;
                end
            end
            S_REQUEST: begin
                if (timeout) begin
                    occ_d     = 2'd0;
                    infl_d    = 1'b0;
                    retries_d = retries_q + RT_W'(1);
                    if (retries_d == RT_W'(MAX_RETRIES)) begin
                        drop_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_BACKOFF;
                    end
                end else if (hs) begin
                    state_d = head_last ? S_DONE : S_STREAM;
                end else if (tvalid_int) begin
                    tmo_d = tmo_q + CNT_W'(1);
                end
            end
            S_STREAM: begin
                if (hs && head_last) begin
                    state_d = S_DONE;
                end
            end
            S_BACKOFF: begin
                if (bo_q == BO_W'(BACKOFF - 1)) begin
                    bo_d     = '0;
                    tmo_d    = '0;
                    rd_ptr_d = start_q;
                    state_d  = S_REQUEST;
                end else begin
                    bo_d = bo_q + BO_W'(1);
                end
            end
            S_DONE: begin
                if (drop_q) begin
                    dropped_d = dropped_q + 16'd1;
                end else begin
                    sent_d = sent_q + 16'd1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            start_q     <= '0;
            end_q       <= '0;
            dest_q      <= '0;
            rd_ptr_q    <= '0;
            retries_q   <= '0;
            tmo_q       <= '0;
            bo_q        <= '0;
            drop_q      <= 1'b0;
            occ_q       <= 2'd0;
            buf_data_q  <= '0;
            buf_last_q  <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            sent_q      <= '0;
            dropped_q   <= '0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            end_q       <= end_d;
            dest_q      <= dest_d;
            rd_ptr_q    <= rd_ptr_d;
            retries_q   <= retries_d;
            tmo_q       <= tmo_d;
            bo_q        <= bo_d;
            drop_q      <= drop_d;
            occ_q       <= occ_d;
            buf_data_q  <= buf_data_d;
            buf_last_q  <= buf_last_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            sent_q      <= sent_d;
            dropped_q   <= dropped_d;
        end
    end

endmodule
